pcie2_rx_credit_return: RTL
===========================

# pcie2_rx_credit_return

Receive-side credit-return engine sitting directly downstream of the pcie2_x1_core VC0 receive interface.
- Snoops the start of every received TLP and classifies it as posted (P), non-posted (NP) or completion.
- Queues one credit record per P/NP TLP.
- When user logic signals that a TLP has been consumed, drives the core's `*_processed_vc0`, `pd_num_vc0`/`npd_num_vc0` and `*_buf_status_vc0` inputs.
- This closes the core's receive flow-control loop.

## Interface
Parameters:
- `DEPTH`, 8: credit-record FIFO depth (power of two, 2..32).
- `PH_THR`, 6: outstanding P headers at or above which `ph_buf_status_vc0` is high.
- `NPH_THR`, 6: same, for NP headers.
- `PD_THR`, 96: outstanding P data credits threshold.
- `NPD_THR`, 8: outstanding NP data credits threshold.

Ports:
- `sys_clk_125` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `rx_data_vc0` in 64: core receive data; DW0 in [63:32].
- `rx_st_vc0` in 1: first beat of a TLP.
- `rx_end_vc0` in 1: last beat of a TLP (monitored only).
- `user_tlp_done` in 1: user has consumed the oldest queued P/NP TLP.
- `done_rdy` out 1: `user_tlp_done` is accepted this cycle.
- `ph_processed_vc0`, `nph_processed_vc0`, `pd_processed_vc0`, `npd_processed_vc0` out 1 each: single-cycle release pulses.
- `pd_num_vc0`, `npd_num_vc0` out 8: data credits released with the pulse.
- `ph_buf_status_vc0`, `nph_buf_status_vc0`, `pd_buf_status_vc0`, `npd_buf_status_vc0` out 1: threshold flags.
- `ovf_err` out 1: sticky; a record was dropped because the FIFO was full.
- `stat_p_cnt`, `stat_np_cnt` out 16: release statistics (see Configuration).

## Operation
- **Header decode** on the `rx_st_vc0` beat:
  - fmt = [62:61], type = [60:56], len = [41:32]; len 0 means 1024 DW.
  - has_data = fmt[1].
  - Completion (type 0101x) produces no record.
  - P = memory write (type 0000x with data) or message (type 10xxx).
  - NP = memory read, I/O read/write, or config read/write.
- **Data credits** cred = ceil(len/4), 9-bit value (1..256); cred = 0 when has_data = 0.
- **Push:** the record {np, has_data, cred} is written in the `rx_st_vc0` cycle.
  - If the FIFO is full, the record is dropped and `ovf_err` sets. Outstanding counters are not changed.
- **Outstanding counters:**
  - Header counters are 6 bits; data counters are 12 bits.
  - They increment on push and decrement on release. Push and release in the same cycle apply both.
  - Status flags are registered comparisons (>= threshold) of the counters.
- **Release FSM:**
  - IDLE: `done_rdy` = !empty. `user_tlp_done` while `done_rdy` pops the head record.
    - Next cycle: pulse `ph_`/`nph_processed`. If has_data, also pulse `pd_`/`npd_processed` with num = min(cred,255).
    - If cred = 256, go to REM; otherwise stay in IDLE.
  - REM: `done_rdy` = 0. Pulse the data processed signal again with num = 1, then return to IDLE.
  - `user_tlp_done` while `done_rdy` = 0 is ignored.
- No read-through: a record pushed in cycle N is poppable from cycle N+1.
- The unused num bus is 0 whenever no pulse is active.

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0, `ovf_err` cleared.
- Reset mid-release aborts the pending pulse; nothing is emitted after reset.
- Release latency: accepted `user_tlp_done` in cycle N gives the processed pulses in cycle N+1. A cred = 256 remainder follows in N+2.
- Throughput: one release per cycle from back-to-back accepted dones (except REM).
- Status flags lag counter changes by 1 cycle.
- A TLP with `rx_st_vc0` and `rx_end_vc0` in the same cycle is handled normally.

## Configuration
- `CREDIT_STATS_EN`
  - Defined: `stat_p_cnt`/`stat_np_cnt` are 16-bit saturating counters of P/NP header releases, cleared by reset.
  - Undefined: both outputs are tied to 0 and no counters are synthesised.

## Structure
- Package `pcie2_rx_cred_pkg` holds:
  - fmt/type constants;
  - the credit-record typedef {np, has_data, cred[8:0]};
  - the FSM state enum;
  - the `ceil_cred` function.
- Sub-module `pcie2_rx_cred_fifo`: synchronous FIFO (DEPTH, record width) with full/empty; no read-through.

## Test plan
- MWr with len=16 pushed, then done → next cycle `ph_processed`=1, `pd_processed`=1, `pd_num_vc0`=4; counters return to 0.
- MRd with len=1 → `nph_processed` only, `npd_processed`=0, `npd_num_vc0`=0.
- MWr with len=0 (1024 DW) → pulse with `pd_num_vc0`=255, next cycle `pd_num_vc0`=1; `done_rdy`=0 during REM.
- Completion (type 01010) → no record; `done_rdy` stays 0.
- 9 MWr headers with DEPTH=8 and no dones → `ovf_err`=1, `ph_buf_status_vc0`=1 (8 ≥ 6), exactly 8 releases follow.
- Push and release in the same cycle with PH count at 6 → count stays 6 and `ph_buf_status_vc0` remains 1; with `CREDIT_STATS_EN`, `stat_p_cnt` increments per release.

Source files
------------

// File: rtl/pcie2_rx_cred_pkg.sv
// pcie2_rx_cred_pkg: TLP type constants, credit record, release FSM states
// and the data-credit helper shared by the receive credit-return engine.
package pcie2_rx_cred_pkg;
    localparam logic [4:0] TYP_MEM  = 5'b00000;
    localparam logic [4:0] TYP_IO   = 5'b00010;
    localparam logic [4:0] TYP_CFG0 = 5'b00100;
    localparam logic [4:0] TYP_MSG  = 5'b10000;

    typedef struct packed {
        logic       np;
        logic       has_data;
        logic [8:0] cred;
    } cred_rec_t;

    typedef enum logic {ST_IDLE, ST_REM} rel_state_t;

    // A length field of zero encodes 1024 DW, i.e. 256 data credits.
    function automatic logic [8:0] ceil_cred(input logic has_data, input logic [9:0] len);
        logic [10:0] l;
        l = ((len == 10'd0) ? 11'd1024 : {1'b0, len}) + 11'd3;
        return has_data ? l[10:2] : 9'd0;
    endfunction
endpackage

// File: rtl/pcie2_rx_cred_fifo.sv
// pcie2_rx_cred_fifo: synchronous credit-record FIFO with full/empty flags;
// a word written in one cycle becomes visible at the head the next cycle.
module pcie2_rx_cred_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 11
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wp, r_rp;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk)
        if (i_push && !o_full) r_mem[r_wp[AW-1:0]] <= i_wdata;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push && !o_full) r_wp <= r_wp + (AW+1)'(1);
            if (i_pop && !o_empty) r_rp <= r_rp + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/pcie2_rx_credit_return.sv
// pcie2_rx_credit_return: queues P/NP credit records from received TLP headers and
// returns them to the core on user consumption. Optional CREDIT_STATS_EN adds release counters.
module pcie2_rx_credit_return
    import pcie2_rx_cred_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int PH_THR  = 6,
    parameter int NPH_THR = 6,
    parameter int PD_THR  = 96,
    parameter int NPD_THR = 8
) (
    input  logic        sys_clk_125,
    input  logic        rst_n,
    input  logic [63:0] rx_data_vc0,
    input  logic        rx_st_vc0,
    input  logic        rx_end_vc0,
    input  logic        user_tlp_done,
    output logic        done_rdy,
    output logic        ph_processed_vc0,
    output logic        nph_processed_vc0,
    output logic        pd_processed_vc0,
    output logic        npd_processed_vc0,
    output logic [7:0]  pd_num_vc0,
    output logic [7:0]  npd_num_vc0,
    output logic        ph_buf_status_vc0,
    output logic        nph_buf_status_vc0,
    output logic        pd_buf_status_vc0,
    output logic        npd_buf_status_vc0,
    output logic        ovf_err,
    output logic [15:0] stat_p_cnt,
    output logic [15:0] stat_np_cnt
);
    logic [4:0]  w_type;
    logic        w_hd, w_p, w_np, w_rec_v, w_push, w_pop, w_full, w_empty, w_unused;
    logic [7:0]  w_num;
    cred_rec_t   w_in, w_head;
    rel_state_t  r_state;
    logic        r_rem_np, r_ovf;
    logic        r_ph_p, r_nph_p, r_pd_p, r_npd_p, r_ph_st, r_nph_st, r_pd_st, r_npd_st;
    logic [7:0]  r_pd_num, r_npd_num;
    logic [5:0]  r_ph_cnt, r_nph_cnt;
    logic [11:0] r_pd_cnt, r_npd_cnt;

    assign w_type   = rx_data_vc0[60:56];
    assign w_hd     = rx_data_vc0[62];
    assign w_unused = ^{rx_end_vc0, rx_data_vc0[63], rx_data_vc0[61], rx_data_vc0[55:42], rx_data_vc0[31:0]};
    assign w_p      = (w_type[4:1] == TYP_MEM[4:1] && w_hd) || w_type[4:3] == TYP_MSG[4:3];
    assign w_np     = (w_type[4:1] == TYP_MEM[4:1] && !w_hd) || w_type == TYP_IO || w_type[4:1] == TYP_CFG0[4:1];
    assign w_in     = '{np: w_np, has_data: w_hd, cred: ceil_cred(w_hd, rx_data_vc0[41:32])};
    assign w_rec_v  = rx_st_vc0 && (w_p || w_np);
    assign w_push   = w_rec_v && !w_full;
    assign done_rdy = (r_state == ST_IDLE) && !w_empty;
    assign w_pop    = user_tlp_done && done_rdy;
    assign w_num    = w_head.cred[8] ? 8'd255 : w_head.cred[7:0];

    pcie2_rx_cred_fifo #(.DEPTH(DEPTH), .W($bits(cred_rec_t))) u_fifo (
        .i_clk(sys_clk_125), .i_rst_n(rst_n), .i_push(w_push), .i_pop(w_pop),
        .i_wdata(w_in), .o_rdata(w_head), .o_full(w_full), .o_empty(w_empty)
    );

    always_ff @(posedge sys_clk_125) begin
        if (!rst_n) begin
            {r_ph_cnt, r_nph_cnt, r_pd_cnt, r_npd_cnt} <= '0;
            {r_ph_st, r_nph_st, r_pd_st, r_npd_st, r_ovf} <= '0;
        end else begin
            r_ph_cnt  <= r_ph_cnt  + 6'(w_push && !w_in.np) - 6'(w_pop && !w_head.np);
            r_nph_cnt <= r_nph_cnt + 6'(w_push && w_in.np)  - 6'(w_pop && w_head.np);
            r_pd_cnt  <= r_pd_cnt  + ((w_push && !w_in.np) ? 12'(w_in.cred) : 12'd0)
                                   - ((w_pop && !w_head.np) ? 12'(w_head.cred) : 12'd0);
            r_npd_cnt <= r_npd_cnt + ((w_push && w_in.np) ? 12'(w_in.cred) : 12'd0)
                                   - ((w_pop && w_head.np) ? 12'(w_head.cred) : 12'd0);
            r_ph_st   <= r_ph_cnt  >= 6'(PH_THR);
            r_nph_st  <= r_nph_cnt >= 6'(NPH_THR);
            r_pd_st   <= r_pd_cnt  >= 12'(PD_THR);
            r_npd_st  <= r_npd_cnt >= 12'(NPD_THR);
            r_ovf     <= r_ovf || (w_rec_v && w_full);
        end
    end

    // A 256-credit TLP cannot fit one 8-bit num, so REM returns the last credit.
    always_ff @(posedge sys_clk_125) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            {r_rem_np, r_ph_p, r_nph_p, r_pd_p, r_npd_p, r_pd_num, r_npd_num} <= '0;
        end else begin
            {r_ph_p, r_nph_p, r_pd_p, r_npd_p, r_pd_num, r_npd_num} <= '0;
            if (r_state == ST_REM) begin
                r_pd_p    <= !r_rem_np;
                r_npd_p   <= r_rem_np;
                r_pd_num  <= r_rem_np ? 8'd0 : 8'd1;
                r_npd_num <= r_rem_np ? 8'd1 : 8'd0;
                r_state   <= ST_IDLE;
            end else if (w_pop) begin
                r_ph_p    <= !w_head.np;
                r_nph_p   <= w_head.np;
                r_pd_p    <= w_head.has_data && !w_head.np;
                r_npd_p   <= w_head.has_data && w_head.np;
                r_pd_num  <= (w_head.has_data && !w_head.np) ? w_num : 8'd0;
                r_npd_num <= (w_head.has_data && w_head.np) ? w_num : 8'd0;
                r_rem_np  <= w_head.np;
                r_state   <= w_head.cred[8] ? ST_REM : ST_IDLE;
            end
        end
    end

`ifdef CREDIT_STATS_EN
    logic [15:0] r_stat_p, r_stat_np;
    always_ff @(posedge sys_clk_125) begin
        if (!rst_n) begin
            r_stat_p  <= '0;
            r_stat_np <= '0;
        end else begin
            if (w_pop && !w_head.np && ~&r_stat_p) r_stat_p <= r_stat_p + 16'd1;
            if (w_pop && w_head.np && ~&r_stat_np) r_stat_np <= r_stat_np + 16'd1;
        end
    end
    assign stat_p_cnt  = r_stat_p;
    assign stat_np_cnt = r_stat_np;
`else
    assign stat_p_cnt  = 16'd0;
    assign stat_np_cnt = 16'd0;
`endif

    assign ph_processed_vc0   = r_ph_p;
    assign nph_processed_vc0  = r_nph_p;
    assign pd_processed_vc0   = r_pd_p;
    assign npd_processed_vc0  = r_npd_p;
    assign pd_num_vc0         = r_pd_num;
    assign npd_num_vc0        = r_npd_num;
    assign ph_buf_status_vc0  = r_ph_st;
    assign nph_buf_status_vc0 = r_nph_st;
    assign pd_buf_status_vc0  = r_pd_st;
    assign npd_buf_status_vc0 = r_npd_st;
    assign ovf_err            = r_ovf;
endmodule
